burst_memory: RTL and testbench
===============================

BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 4: address width in bits.
REQ-003 Parameter DEPTH, default 16: number of words; SHALL satisfy DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter LEN_WIDTH, default 3: burst-length field width; a burst is len_i+1 beats, up to 2**LEN_WIDTH beats.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk_i  input  1  clock; all logic samples on the rising edge.
REQ-007 rst_i  input  1  synchronous active-high reset.
REQ-008 valid_i  input  1  request/beat valid.
REQ-009 ready_o  output  1  block can accept a request or write beat this cycle.
REQ-010 wr_rd_en_i  input  1  direction: 1 = write, 0 = read; sampled at command acceptance only.
REQ-011 addr_i  input  ADDR_WIDTH  burst start address; sampled at command acceptance only.
REQ-012 len_i  input  LEN_WIDTH  beats minus one; sampled at command acceptance only.
REQ-013 wdata_i  input  WIDTH  write data for the current beat.
REQ-014 wstrb_i  input  WIDTH/8  per-byte write enable for the current beat.
REQ-015 rdata_o  output  WIDTH  read data.
REQ-016 rvalid_o  output  1  rdata_o holds a valid read beat.
REQ-017 rlast_o  output  1  current read beat is the final beat of the burst.
REQ-018 err_o  output  1  one-cycle pulse: current beat targeted an address >= DEPTH.

Function
REQ-019 A handshake (beat accepted) SHALL occur on a rising edge where valid_i=1 and ready_o=1.
REQ-020 FSM states SHALL be IDLE, WRITE and READ; ready_o=1 in IDLE and WRITE, 0 in READ.
REQ-021 IDLE, write handshake: the first beat (wdata_i/wstrb_i) SHALL be written at addr_i in the same cycle; if len_i=0, stay IDLE, else go to WRITE with remaining = len_i.
REQ-022 WRITE, each handshake: write the beat at the next sequential address and decrement remaining; return to IDLE after the final beat.
REQ-023 WRITE with valid_i=0: hold state, address and count; no write (stall permitted indefinitely).
REQ-024 Write: only bytes with wstrb_i[b]=1 SHALL be updated; wstrb_i=0 is a legal no-op beat that still counts.
REQ-025 IDLE, read handshake: go to READ; beat k (k=0..len_i) SHALL appear on rdata_o with rvalid_o=1 in cycle k+1 after acceptance, one beat per cycle, no gaps.
REQ-026 rlast_o SHALL be 1 only with the final read beat; return to IDLE in that same cycle, so ready_o=1 the cycle after rlast_o.
REQ-027 Beat address SHALL be (start + beat index) modulo 2**ADDR_WIDTH (wrap-around).
REQ-028 A beat whose address is >= DEPTH: write SHALL be dropped; read SHALL return 0; err_o=1 in that beat's cycle (write: handshake cycle; read: cycle of rvalid_o); the burst continues.
REQ-029 rdata_o, rvalid_o and rlast_o SHALL be registered; when rvalid_o=0, rdata_o SHALL be 0.
REQ-030 valid_i while in READ SHALL be ignored; the requester holds the command until ready_o=1.

Reset
REQ-031 When rst_i=1 at a rising edge: state IDLE; all DEPTH words cleared to 0; ready_o=0 during reset, 1 from the first cycle after rst_i deasserts; rvalid_o, rlast_o and err_o 0; rdata_o 0.
REQ-032 Reset mid-burst SHALL abort the burst immediately; beats not yet written SHALL remain 0 after the clear.

Verification
REQ-033 Single write addr=3, len=0, data=16'hA5A5, wstrb=2'b11, then read addr=3, len=0 -> rdata_o=16'hA5A5, rvalid_o=rlast_o=1 one cycle after acceptance.
REQ-034 Write burst addr=14, len=3, data 1,2,3,4 -> words 14,15,0,1 = 1,2,3,4 (wrap); read burst addr=14, len=3 returns 1,2,3,4 on consecutive cycles, rlast_o on 4.
REQ-035 Byte strobe: write 16'h1234 to addr=5, then 16'hFFFF with wstrb=2'b01 -> read returns 16'h12FF.
REQ-036 Stall: write burst len=2 with valid_i=0 for 3 cycles between beats 1 and 2 -> all three words written correctly; FSM stays in WRITE during the gap.
REQ-037 DEPTH=12, ADDR_WIDTH=4: read addr=10, len=3 -> beats 2 and 3 (addresses 12, 13) return 0 with err_o=1 in their cycles.
REQ-038 Assert rst_i during beat 2 of a len=3 write to addr=0 -> ready_o=0 during reset, 1 the cycle after deassertion; all words read 0 afterward.

Source files
------------

// File: rtl/burst_memory.sv
// Burst-capable word memory with per-byte write strobes, wrap-around
// burst addressing and out-of-range error reporting.
module burst_memory #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LEN_WIDTH  = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic [WIDTH/8-1:0]     wstrb_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   rvalid_o,
  output logic                   rlast_o,
  output logic                   err_o
);

  localparam int unsigned STRB_W = WIDTH / 8;
  localparam int unsigned CMP_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [LEN_WIDTH-1:0]    rem_q;
  logic [LEN_WIDTH-1:0]    next_rem;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic                    handshake;
  logic                    in_range;
  logic                    wr_en;
  logic                    rd_en;
  logic                    rd_last;
  logic                    rd_err_q;
  logic [WIDTH-1:0]        mem [DEPTH];

  // Requests and write beats are accepted outside of reset whenever no read burst is streaming.
  assign ready_o   = !rst_i && (state != READ);
  assign handshake = valid_i && ready_o;

  // Write errors flag the handshake cycle itself; read errors travel with the registered beat.
  assign err_o = (wr_en && !in_range) || rd_err_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, beat address and burst bookkeeping.
  always_comb begin
    next_state = state;
    next_addr  = addr_q;
    next_rem   = rem_q;
    beat_addr  = addr_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_last    = 1'b0;
    case (state)
      IDLE: begin
        beat_addr = addr_i;
        if (handshake) begin
          next_addr = addr_i + ADDR_WIDTH'(1);
          next_rem  = len_i;
          if (wr_rd_en_i) begin
            wr_en = 1'b1;
            if (len_i != '0) begin
              next_state = WRITE;
            end
          end else begin
            rd_en      = 1'b1;
            rd_last    = (len_i == '0);
            next_state = READ;
          end
        end
      end
      WRITE: begin
        if (handshake) begin
          wr_en     = 1'b1;
          next_addr = addr_q + ADDR_WIDTH'(1);
          next_rem  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            next_state = IDLE;
          end
        end
      end
      READ: begin
        // rem_q counts beats still to emit after the one currently on rdata_o.
        if (rem_q == '0) begin
          next_state = IDLE;
        end else begin
          rd_en     = 1'b1;
          rd_last   = (rem_q == LEN_WIDTH'(1));
          next_addr = addr_q + ADDR_WIDTH'(1);
          next_rem  = rem_q - LEN_WIDTH'(1);
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign in_range = CMP_W'(beat_addr) < CMP_W'(DEPTH);

  // Storage, burst counters and registered read channel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      addr_q   <= '0;
      rem_q    <= '0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      rlast_o  <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      addr_q   <= next_addr;
      rem_q    <= next_rem;
      rvalid_o <= rd_en;
      rlast_o  <= rd_last;
      rd_err_q <= rd_en && !in_range;
      rdata_o  <= (rd_en && in_range) ? mem[beat_addr] : '0;
      if (wr_en && in_range) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (wstrb_i[b]) begin
            mem[beat_addr][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_burst_memory.sv
// Randomized bench for burst_memory against an array-based reference model.
module tb_burst_memory;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned D  = 12;
  localparam int unsigned LW = 3;
  localparam int unsigned NA = 16;

  logic          clk;
  logic          rst;
  logic          valid;
  logic          ready;
  logic          wr_rd_en;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic [W-1:0]  wdata;
  logic [1:0]    wstrb;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          rlast;
  logic          err;

  logic [W-1:0]  model [NA];
  logic [W-1:0]  wbuf  [8];
  logic [1:0]    sbuf  [8];
  int            total;
  int            bad;

  burst_memory #(
    .WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D), .LEN_WIDTH(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
    .wr_rd_en_i(wr_rd_en), .addr_i(addr), .len_i(len),
    .wdata_i(wdata), .wstrb_i(wstrb), .rdata_o(rdata),
    .rvalid_o(rvalid), .rlast_o(rlast), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] expect_word(input int a);
    return (a < int'(D)) ? model[a] : '0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < int'(NA); i++) model[i] = '0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Write burst from wbuf/sbuf, optionally pausing stall_n cycles before beat stall_at.
  task automatic write_burst(input int start, input int n_len, input int stall_at, input int stall_n);
    for (int k = 0; k <= n_len; k++) begin
      int a;
      a = (start + k) % int'(NA);
      if (k != 0 && k == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          valid = 1'b0;
          wdata = W'($urandom);
          wstrb = 2'b11;
          #1;
          check("stall_ready", 32'(ready), 32'd1);
          check("stall_err", 32'(err), 32'd0);
          @(posedge clk); #1;
        end
      end
      valid    = 1'b1;
      wr_rd_en = (k == 0) ? 1'b1 : 1'($urandom);
      addr     = (k == 0) ? AW'(start) : AW'($urandom);
      len      = (k == 0) ? LW'(n_len) : LW'($urandom);
      wdata    = wbuf[k];
      wstrb    = sbuf[k];
      #1;
      check("wr_ready", 32'(ready), 32'd1);
      check("wr_err", 32'(err), 32'(a >= int'(D)));
      @(posedge clk); #1;
      if (a < int'(D)) begin
        for (int b = 0; b < 2; b++) begin
          if (sbuf[k][b]) model[a][b*8 +: 8] = wbuf[k][b*8 +: 8];
        end
      end
    end
    valid = 1'b0;
    check("wr_done_ready", 32'(ready), 32'd1);
  endtask

  // Read burst; junk on the request inputs during streaming must be ignored.
  task automatic read_burst(input int start, input int n_len);
    valid    = 1'b1;
    wr_rd_en = 1'b0;
    addr     = AW'(start);
    len      = LW'(n_len);
    #1;
    check("rd_ready", 32'(ready), 32'd1);
    check("rd_acc_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k <= n_len; k++) begin
      int a;
      a = (start + k) % int'(NA);
      check("rd_valid", 32'(rvalid), 32'd1);
      check("rd_data", 32'(rdata), 32'(expect_word(a)));
      check("rd_last", 32'(rlast), 32'(k == n_len));
      check("rd_err", 32'(err), 32'(a >= int'(D)));
      check("rd_busy", 32'(ready), 32'd0);
      valid    = 1'($urandom);
      wr_rd_en = 1'($urandom);
      addr     = AW'($urandom);
      len      = LW'($urandom);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("rd_end_valid", 32'(rvalid), 32'd0);
    check("rd_end_data", 32'(rdata), 32'd0);
    check("rd_end_last", 32'(rlast), 32'd0);
    check("rd_end_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    valid    = 1'b0;
    wr_rd_en = 1'b0;
    addr     = '0;
    len      = '0;
    wdata    = '0;
    wstrb    = '0;
    clear_model();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(ready), 32'd1);
    read_burst(0, 7);
    read_burst(8, 7);

    // Single write then single read.
    wbuf[0] = 16'hA5A5; sbuf[0] = 2'b11;
    write_burst(3, 0, 0, 0);
    read_burst(3, 0);

    // Wrapping burst: 14 and 15 are beyond DEPTH, 0 and 1 land.
    for (int k = 0; k < 4; k++) begin wbuf[k] = W'(k + 1); sbuf[k] = 2'b11; end
    write_burst(14, 3, 0, 0);
    read_burst(14, 3);

    // Byte strobe merge.
    wbuf[0] = 16'h1234; sbuf[0] = 2'b11;
    write_burst(5, 0, 0, 0);
    wbuf[0] = 16'hFFFF; sbuf[0] = 2'b01;
    write_burst(5, 0, 0, 0);
    read_burst(5, 0);

    // Stall between beats 1 and 2.
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
    sbuf[0] = 2'b11; sbuf[1] = 2'b11; sbuf[2] = 2'b11;
    write_burst(6, 2, 2, 3);
    read_burst(6, 2);

    // Read crossing DEPTH.
    read_burst(10, 3);

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      int st;
      int ln;
      st = int'($urandom_range(0, NA - 1));
      ln = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 8; k++) begin
          wbuf[k] = W'($urandom);
          sbuf[k] = 2'($urandom);
        end
        write_burst(st, ln, int'($urandom_range(1, 7)), int'($urandom_range(0, 3)));
      end else begin
        read_burst(st, ln);
      end
      idle(int'($urandom_range(0, 2)));
    end

    // Reset during beat 2 of a len=3 write to address 0.
    for (int k = 0; k < 3; k++) begin wbuf[k] = W'($urandom) | 16'h0101; end
    for (int k = 0; k < 2; k++) begin
      valid    = 1'b1;
      wr_rd_en = 1'b1;
      addr     = '0;
      len      = LW'(3);
      wdata    = wbuf[k];
      wstrb    = 2'b11;
      @(posedge clk); #1;
    end
    valid = 1'b1;
    wdata = wbuf[2];
    rst   = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("midrst_ready2", 32'(ready), 32'd0);
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_rdata", 32'(rdata), 32'd0);
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    check("midrst_release_ready", 32'(ready), 32'd1);
    clear_model();
    read_burst(0, 7);
    read_burst(8, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
